// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the ID/EX register and the EX-stage mul/div unit.
// Latency: n/a (wires only).
// Backpressure: stall from the unit freezes the ID/EX register.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] busAEx;
    logic [XLEN-1:0] busBEx;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div_by_zero;

    modport master (
        output start, op, busAEx, busBEx, flush,
        input  busy, stall, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, busAEx, busBEx, flush,
        output busy, stall, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide into HI/LO, signed and unsigned.
// Latency: XLEN RUN cycles + 1 FIX cycle; done pulses the cycle after FIX.
// Backpressure: stall holds the ID/EX register from the start cycle through FIX; start while busy is dropped.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_muldiv_unit_if.slave mdu
);
    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              is_div;
    logic [XLEN-1:0]   a_mag, b_mag, a_raw;
    logic              res_neg, rem_neg;
    logic [2*XLEN-1:0] acc, acc_step;
    logic              accept, step, finish;

    logic [XLEN-1:0]   hi_q, lo_q;
    logic              done_q, dbz_q;

    // Operand conditioning at the accept edge: signed ops work on magnitudes.
    logic              sgn_op_in, a_neg_in, b_neg_in;
    logic [XLEN-1:0]   a_abs_in, b_abs_in;

    assign sgn_op_in = ~mdu.op[0];
    assign a_neg_in  = sgn_op_in & mdu.busAEx[XLEN-1];
    assign b_neg_in  = sgn_op_in & mdu.busBEx[XLEN-1];
    assign a_abs_in  = a_neg_in ? -mdu.busAEx : mdu.busAEx;
    assign b_abs_in  = b_neg_in ? -mdu.busBEx : mdu.busBEx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mdu.start && !mdu.flush) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (mdu.flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_LAST) state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
                finish    = !mdu.flush;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One iteration. Multiply: acc = {partial, multiplier}, add-then-shift-right.
    // Divide: acc = {remainder, quotient}, shift-left then trial-subtract.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_sh   = acc[2*XLEN-1:XLEN-1];
        div_ge   = div_sh >= {1'b0, b_mag};
        div_diff = div_sh[XLEN-1:0] - b_mag;
        if (is_div) begin
            acc_step = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                              : {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign correction and divide-by-zero result, applied in FIX.
    logic [XLEN-1:0] fix_hi, fix_lo;
    logic            fix_dbz;

    always_comb begin
        fix_hi  = acc[2*XLEN-1:XLEN];
        fix_lo  = acc[XLEN-1:0];
        fix_dbz = 1'b0;
        if (!is_div) begin
            if (res_neg) {fix_hi, fix_lo} = -acc;
        end else if (b_mag == '0) begin
            fix_hi  = a_raw;
            fix_lo  = '1;
            fix_dbz = 1'b1;
        end else begin
            if (res_neg) fix_lo = -acc[XLEN-1:0];
            if (rem_neg) fix_hi = -acc[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            a_mag   <= '0;
            b_mag   <= '0;
            a_raw   <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            acc     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                is_div  <= mdu.op[1];
                a_mag   <= a_abs_in;
                b_mag   <= b_abs_in;
                a_raw   <= mdu.busAEx;
                res_neg <= a_neg_in ^ b_neg_in;
                rem_neg <= a_neg_in;
                cnt     <= '0;
                acc     <= {{XLEN{1'b0}}, (mdu.op[1] ? a_abs_in : b_abs_in)};
                dbz_q   <= 1'b0;
            end else if (step) begin
                acc <= acc_step;
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                hi_q  <= fix_hi;
                lo_q  <= fix_lo;
                dbz_q <= fix_dbz;
            end
        end
    end

    assign mdu.busy        = (state != S_IDLE);
    assign mdu.stall       = (state != S_IDLE) | (mdu.start & (state == S_IDLE));
    assign mdu.done        = done_q;
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;
    assign mdu.div_by_zero = dbz_q;
endmodule
